mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

- Shares the core's single SRAM-like memory port between the instruction-fetch side (IF) and the data side (MEM stage), one transaction outstanding at a time.
- Generates `stallreq_from_ic` / `stallreq_from_dc` for the pipeline controller.
- Discards in-flight fetch responses on pipeline flush (exception/eret).
- Sits between the IF/MEM stages and the cache/AXI bridge.

## Interface
Parameters: none.

Ports:
- clk  in  1  core clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  pipeline flush from controller
- inst_req  in  1  fetch request; held until inst_addr_ok
- inst_addr  in  32  fetch address
- inst_addr_ok  out  1  fetch address accepted
- inst_data_ok  out  1  fetch data valid
- inst_rdata  out  32  fetch data
- data_req  in  1  load/store request; held until data_addr_ok
- data_wr  in  1  1 = store
- data_size  in  2  0 = byte, 1 = half, 2 = word
- data_wstrb  in  4  byte enables
- data_addr  in  32  data address
- data_wdata  in  32  store data
- data_addr_ok  out  1  data address accepted
- data_data_ok  out  1  load data valid / store done
- data_rdata  out  32  load data
- bus_req, bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata  out  1/1/2/4/32/32  memory port request
- bus_addr_ok, bus_data_ok  in  1  memory port handshakes
- bus_rdata  in  32  memory port read data
- stallreq_from_ic  out  1  fetch side waiting
- stallreq_from_dc  out  1  data side waiting

## Operation
- FSM states: IDLE, I_ADDR, I_DATA, D_ADDR, D_DATA.
- Registered state: `drop` flag (flush-discard) and `last` (last granted side).
- IDLE:
  - data_req only -> D_ADDR.
  - inst_req only -> I_ADDR.
  - Both requesting -> D_ADDR (fixed data priority; see Configuration).
  - No request -> stay IDLE.
  - bus_req = 0.
- I_ADDR / D_ADDR:
  - bus_req = 1.
  - Bus fields muxed from the granted side; inst side forces wr = 0, size = 2, wstrb = 0.
  - bus_addr_ok -> granted side's addr_ok = 1 the same cycle; next state is the corresponding *_DATA.
- I_DATA / D_DATA:
  - bus_req = 0.
  - bus_data_ok -> granted side's data_ok = 1 the same cycle, rdata = bus_rdata; next state IDLE.
- addr_ok/data_ok are never asserted to the non-granted side.
- Flush:
  - In I_ADDR before bus_addr_ok: withdraw bus_req, go to IDLE.
  - In I_ADDR in the same cycle as bus_addr_ok: accept the address, set `drop`.
  - In I_DATA: set `drop`.
  - While `drop` = 1, bus_data_ok completes the transaction with inst_data_ok = 0; `drop` clears on leaving I_DATA.
  - Data transactions are never aborted or dropped.
- Stall outputs (combinational):
  - stallreq_from_ic = (inst_req & ~inst_addr_ok) | (state == I_DATA & ~drop & ~inst_data_ok).
  - stallreq_from_dc = (data_req & ~data_addr_ok) | (state == D_DATA & ~data_data_ok).
- rdata outputs pass bus_rdata through unregistered; they are don't-care when data_ok = 0.

## Timing
- Reset: state IDLE, drop = 0, last = inst.
  - All ok/req outputs 0; stallreq outputs follow their equations (0 when no request).
- Reset mid-transaction: returns to IDLE next edge; the outstanding bus transaction is abandoned, and the bridge is reset by the same rst.
- Arbitration latency: a request seen in IDLE at cycle N -> bus_req at N+1.
- Best case, request at N with bus_addr_ok at N+1 and bus_data_ok at N+2:
  - addr_ok at N+1, data_ok at N+2, back in IDLE at N+3.
- Next grant is decided in IDLE at N+3; there is no back-to-back issue from a *_DATA state.
- Simultaneous flush and bus_data_ok in I_DATA: the data is dropped.

## Configuration
- `MEM_ARB_RR_EN`:
  - Defined: on simultaneous requests in IDLE, grant goes to the side opposite `last`; `last` updates on every grant.
  - Undefined: fixed data priority, and `last` is unused/optimized away.
- Single-request behaviour is identical in both builds.

## Test plan
- Fetch alone: inst_req, inst_addr = 0xbfc00000, bus_addr_ok at cycle 1, bus_data_ok with 0x3c080001 at cycle 2 -> inst_addr_ok@1, inst_data_ok@2 with rdata 0x3c080001; stallreq_from_ic high cycles 0-1, low at 2.
- Simultaneous inst_req and data_req (store 0xdeadbeef to 0x80000010, wstrb = 0xf) -> D_ADDR first with bus_wr = 1; the inst grant starts after the data_ok.
  - With `MEM_ARB_RR_EN`, a second simultaneous pair is granted to inst.
- Flush in I_DATA before bus_data_ok -> the transaction completes on the bus, inst_data_ok stays 0, stallreq_from_ic is 0 after the flush, and the next fetch proceeds normally.
- Flush in I_ADDR with bus_addr_ok = 0 -> bus_req drops the next cycle, state IDLE, no inst_addr_ok.
- Byte load (size = 0, addr 0x80000003) with bus_addr_ok delayed 3 cycles -> bus fields stay stable; stallreq_from_dc stays high until data_data_ok.
- rst asserted in D_DATA -> next cycle state IDLE, bus_req = 0, all ok outputs 0.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//
// Shares the core's single SRAM-like memory port between the instruction
// fetch side (IF) and the data side (MEM stage), one transaction outstanding
// at a time. Produces stall requests for the pipeline controller and quietly
// discards fetch responses that belong to a flushed instruction stream.
//
// Ports:
//   clk, rst                    core clock, synchronous active-high reset
//   flush                       pipeline flush (exception / eret)
//   inst_req/inst_addr          fetch request, held until inst_addr_ok
//   inst_addr_ok/data_ok/rdata  fetch handshakes and read data
//   data_req/wr/size/wstrb/addr/wdata   load/store request, held until data_addr_ok
//   data_addr_ok/data_ok/rdata  load/store handshakes and load data
//   bus_*                       request side of the shared memory port
//   bus_addr_ok/data_ok/rdata   response side of the shared memory port
//   stallreq_from_ic/dc         fetch / data side is waiting on memory
//
// Build option:
//   MEM_ARB_RR_EN  when defined, simultaneous requests alternate between the
//                  two sides; otherwise the data side always wins.

module mem_bus_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata,
  output logic        stallreq_from_ic,
  output logic        stallreq_from_dc
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    I_ADDR = 3'd1,
    I_DATA = 3'd2,
    D_ADDR = 3'd3,
    D_DATA = 3'd4
  } state_t;

  state_t state_q, state_d;
  logic   drop_q, drop_d;
  logic   grant_data;

`ifdef MEM_ARB_RR_EN
  // last_q = 1 means the data side received the most recent grant
  logic last_q, last_d;

  // On a tie the side that did not win last time gets the port
  assign grant_data = data_req & (~inst_req | ~last_q);
`else
  assign grant_data = data_req;
`endif

  // Next-state logic. A flush before the fetch address is accepted simply
  // withdraws the request; once the bridge owns the address the transaction
  // must run to completion, so the response is marked for discard instead.
  always_comb begin
    state_d = state_q;
    drop_d  = drop_q;
`ifdef MEM_ARB_RR_EN
    last_d  = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (data_req | inst_req) begin
          state_d = grant_data ? D_ADDR : I_ADDR;
`ifdef MEM_ARB_RR_EN
          last_d  = grant_data;
`endif
        end
      end
      I_ADDR: begin
        if (bus_addr_ok) begin
          state_d = I_DATA;
          if (flush) drop_d = 1'b1;
        end else if (flush) begin
          state_d = IDLE;
        end
      end
      I_DATA: begin
        if (bus_data_ok) begin
          state_d = IDLE;
          drop_d  = 1'b0;
        end else if (flush) begin
          drop_d = 1'b1;
        end
      end
      D_ADDR: begin
        if (bus_addr_ok) state_d = D_DATA;
      end
      D_DATA: begin
        if (bus_data_ok) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      drop_q  <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
`ifdef MEM_ARB_RR_EN
      last_q  <= last_d;
`endif
    end
  end

  // Request fields are only meaningful while bus_req is high; they are held
  // at zero otherwise so the bridge sees quiet lines between transactions.
  always_comb begin
    bus_req   = 1'b0;
    bus_wr    = 1'b0;
    bus_size  = 2'd0;
    bus_wstrb = 4'd0;
    bus_addr  = 32'd0;
    bus_wdata = 32'd0;
    case (state_q)
      I_ADDR: begin
        bus_req  = 1'b1;
        bus_size = 2'd2;
        bus_addr = inst_addr;
      end
      D_ADDR: begin
        bus_req   = 1'b1;
        bus_wr    = data_wr;
        bus_size  = data_size;
        bus_wstrb = data_wstrb;
        bus_addr  = data_addr;
        bus_wdata = data_wdata;
      end
      default: ;
    endcase
  end

  // A flush arriving together with the fetch data also kills that data
  assign inst_addr_ok = (state_q == I_ADDR) & bus_addr_ok;
  assign inst_data_ok = (state_q == I_DATA) & bus_data_ok & ~drop_q & ~flush;
  assign data_addr_ok = (state_q == D_ADDR) & bus_addr_ok;
  assign data_data_ok = (state_q == D_DATA) & bus_data_ok;

  assign inst_rdata = bus_rdata;
  assign data_rdata = bus_rdata;

  assign stallreq_from_ic = (inst_req & ~inst_addr_ok) |
                            ((state_q == I_DATA) & ~drop_q & ~inst_data_ok);
  assign stallreq_from_dc = (data_req & ~data_addr_ok) |
                            ((state_q == D_DATA) & ~data_data_ok);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter
//
// Cycle-by-cycle directed vectors for mem_bus_arbiter. Each table row holds
// the inputs for one clock cycle and the outputs expected in that cycle;
// the arbitration order for back-to-back simultaneous requests is exercised
// in a hand-written sequence because it depends on MEM_ARB_RR_EN.

module tb_mem_bus_arbiter;

  localparam logic [31:0] IA = 32'hbfc00000;
  localparam logic [31:0] WD = 32'hdeadbeef;
`ifdef MEM_ARB_RR_EN
  localparam bit INST_FIRST = 1'b1;
`else
  localparam bit INST_FIRST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        bus_req, bus_wr;
  logic [1:0]  bus_size;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_addr_ok, bus_data_ok;
  logic [31:0] bus_rdata;
  logic        stallreq_from_ic, stallreq_from_dc;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter dut (
    .clk(clk), .rst(rst), .flush(flush),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_wstrb(bus_wstrb),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata),
    .stallreq_from_ic(stallreq_from_ic), .stallreq_from_dc(stallreq_from_dc)
  );

  // exp_ctl packs {bus_req, inst_addr_ok, inst_data_ok, data_addr_ok,
  // data_data_ok, stallreq_from_ic, stallreq_from_dc}
  typedef struct {
    logic        rst, flush, ireq, dreq, dwr;
    logic [1:0]  dsize;
    logic [3:0]  dwstrb;
    logic [31:0] daddr;
    logic        baok, bdok;
    logic [31:0] brdata;
    logic [6:0]  exp_ctl;
    logic        exp_bwr;
    logic [1:0]  exp_bsize;
    logic [3:0]  exp_bwstrb;
    logic [31:0] exp_baddr;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input logic r, input logic fl, input logic ir, input logic dr,
                        input logic wr, input logic [1:0] sz, input logic [3:0] st,
                        input logic [31:0] da, input logic ao, input logic dok,
                        input logic [31:0] rd, input logic [6:0] ctl, input logic ewr,
                        input logic [1:0] esz, input logic [3:0] est, input logic [31:0] ea);
    vec_t v;
    v.rst = r; v.flush = fl; v.ireq = ir; v.dreq = dr; v.dwr = wr; v.dsize = sz;
    v.dwstrb = st; v.daddr = da; v.baok = ao; v.bdok = dok; v.brdata = rd;
    v.exp_ctl = ctl; v.exp_bwr = ewr; v.exp_bsize = esz; v.exp_bwstrb = est; v.exp_baddr = ea;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic applyStimulus(input vec_t v);
    rst         = v.rst;
    flush       = v.flush;
    inst_req    = v.ireq;
    inst_addr   = IA;
    data_req    = v.dreq;
    data_wr     = v.dwr;
    data_size   = v.dsize;
    data_wstrb  = v.dwstrb;
    data_addr   = v.daddr;
    data_wdata  = WD;
    bus_addr_ok = v.baok;
    bus_data_ok = v.bdok;
    bus_rdata   = v.brdata;
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("row%0d", idx);
    check({tag, "_ctl"}, 64'({bus_req, inst_addr_ok, inst_data_ok, data_addr_ok,
                              data_data_ok, stallreq_from_ic, stallreq_from_dc}),
          64'(v.exp_ctl));
    if (v.exp_ctl[6])
      check({tag, "_busfields"}, 64'({bus_wr, bus_size, bus_wstrb, bus_addr}),
            64'({v.exp_bwr, v.exp_bsize, v.exp_bwstrb, v.exp_baddr}));
    if (v.exp_ctl[6] && v.exp_bwr)
      check({tag, "_wdata"}, 64'(bus_wdata), 64'(WD));
    if (v.exp_ctl[4])
      check({tag, "_inst_rdata"}, 64'(inst_rdata), 64'(v.brdata));
    if (v.exp_ctl[2])
      check({tag, "_data_rdata"}, 64'(data_rdata), 64'(v.brdata));
  endtask

  initial begin
    //     rst fl ir dr wr sz    st     daddr          ao do rdata          ctl         wr sz    st     baddr
    // reset state
    addVec(1, 0, 0, 0, 0, 2'd0, 4'h0, 32'h0,         0, 0, 32'h0,         7'b0000000, 0, 2'd0, 4'h0, 32'h0);
    // fetch alone
    addVec(0, 0, 1, 0, 0, 2'd0, 4'h0, 32'h0,         0, 0, 32'h0,         7'b0000010, 0, 2'd0, 4'h0, 32'h0);
    addVec(0, 0, 1, 0, 0, 2'd0, 4'h0, 32'h0,         1, 0, 32'h0,         7'b1100000, 0, 2'd2, 4'h0, IA);
    addVec(0, 0, 0, 0, 0, 2'd0, 4'h0, 32'h0,         0, 1, 32'h3c080001,  7'b0010000, 0, 2'd0, 4'h0, 32'h0);
    addVec(0, 0, 0, 0, 0, 2'd0, 4'h0, 32'h0,         0, 0, 32'h0,         7'b0000000, 0, 2'd0, 4'h0, 32'h0);
    // simultaneous store + fetch: data first, fetch after data_ok
    addVec(0, 0, 1, 1, 1, 2'd2, 4'hf, 32'h80000010,  0, 0, 32'h0,         7'b0000011, 0, 2'd0, 4'h0, 32'h0);
    addVec(0, 0, 1, 1, 1, 2'd2, 4'hf, 32'h80000010,  0, 0, 32'h0,         7'b1000011, 1, 2'd2, 4'hf, 32'h80000010);
    addVec(0, 0, 1, 1, 1, 2'd2, 4'hf, 32'h80000010,  1, 0, 32'h0,         7'b1001010, 1, 2'd2, 4'hf, 32'h80000010);
    addVec(0, 0, 1, 0, 0, 2'd0, 4'h0, 32'h0,         0, 1, 32'h0,         7'b0000110, 0, 2'd0, 4'h0, 32'h0);
    addVec(0, 0, 1, 0, 0, 2'd0, 4'h0, 32'h0,         0, 0, 32'h0,         7'b0000010, 0, 2'd0, 4'h0, 32'h0);
    addVec(0, 0, 1, 0, 0, 2'd0, 4'h0, 32'h0,         1, 0, 32'h0,         7'b1100000, 0, 2'd2, 4'h0, IA);
    addVec(0, 0, 0, 0, 0, 2'd0, 4'h0, 32'h0,         0, 1, 32'h12345678,  7'b0010000, 0, 2'd0, 4'h0, 32'h0);
    addVec(0, 0, 0, 0, 0, 2'd0, 4'h0, 32'h0,         0, 0, 32'h0,         7'b0000000, 0, 2'd0, 4'h0, 32'h0);
    // flush in I_DATA, then a normal fetch
    addVec(0, 0, 1, 0, 0, 2'd0, 4'h0, 32'h0,         0, 0, 32'h0,         7'b0000010, 0, 2'd0, 4'h0, 32'h0);
    addVec(0, 0, 1, 0, 0, 2'd0, 4'h0, 32'h0,         1, 0, 32'h0,         7'b1100000, 0, 2'd2, 4'h0, IA);
    addVec(0, 1, 0, 0, 0, 2'd0, 4'h0, 32'h0,         0, 0, 32'h0,         7'b0000010, 0, 2'd0, 4'h0, 32'h0);
    addVec(0, 0, 0, 0, 0, 2'd0, 4'h0, 32'h0,         0, 0, 32'h0,         7'b0000000, 0, 2'd0, 4'h0, 32'h0);
    addVec(0, 0, 0, 0, 0, 2'd0, 4'h0, 32'h0,         0, 1, 32'haaaa5555,  7'b0000000, 0, 2'd0, 4'h0, 32'h0);
    addVec(0, 0, 1, 0, 0, 2'd0, 4'h0, 32'h0,         0, 0, 32'h0,         7'b0000010, 0, 2'd0, 4'h0, 32'h0);
    addVec(0, 0, 1, 0, 0, 2'd0, 4'h0, 32'h0,         1, 0, 32'h0,         7'b1100000, 0, 2'd2, 4'h0, IA);
    addVec(0, 0, 0, 0, 0, 2'd0, 4'h0, 32'h0,         0, 1, 32'h11112222,  7'b0010000, 0, 2'd0, 4'h0, 32'h0);
    // flush in I_ADDR without bus_addr_ok
    addVec(0, 0, 1, 0, 0, 2'd0, 4'h0, 32'h0,         0, 0, 32'h0,         7'b0000010, 0, 2'd0, 4'h0, 32'h0);
    addVec(0, 1, 1, 0, 0, 2'd0, 4'h0, 32'h0,         0, 0, 32'h0,         7'b1000010, 0, 2'd2, 4'h0, IA);
    addVec(0, 0, 0, 0, 0, 2'd0, 4'h0, 32'h0,         0, 0, 32'h0,         7'b0000000, 0, 2'd0, 4'h0, 32'h0);
    // byte load with bus_addr_ok delayed three cycles
    addVec(0, 0, 0, 1, 0, 2'd0, 4'h0, 32'h80000003,  0, 0, 32'h0,         7'b0000001, 0, 2'd0, 4'h0, 32'h0);
    addVec(0, 0, 0, 1, 0, 2'd0, 4'h0, 32'h80000003,  0, 0, 32'h0,         7'b1000001, 0, 2'd0, 4'h0, 32'h80000003);
    addVec(0, 0, 0, 1, 0, 2'd0, 4'h0, 32'h80000003,  0, 0, 32'h0,         7'b1000001, 0, 2'd0, 4'h0, 32'h80000003);
    addVec(0, 0, 0, 1, 0, 2'd0, 4'h0, 32'h80000003,  0, 0, 32'h0,         7'b1000001, 0, 2'd0, 4'h0, 32'h80000003);
    addVec(0, 0, 0, 1, 0, 2'd0, 4'h0, 32'h80000003,  1, 0, 32'h0,         7'b1001000, 0, 2'd0, 4'h0, 32'h80000003);
    addVec(0, 0, 0, 0, 0, 2'd0, 4'h0, 32'h0,         0, 0, 32'h0,         7'b0000001, 0, 2'd0, 4'h0, 32'h0);
    addVec(0, 0, 0, 0, 0, 2'd0, 4'h0, 32'h0,         0, 1, 32'h000000ef,  7'b0000100, 0, 2'd0, 4'h0, 32'h0);
    // reset while in D_DATA; a stray bus_data_ok afterwards must be ignored
    addVec(0, 0, 0, 1, 1, 2'd2, 4'hf, 32'h80000010,  0, 0, 32'h0,         7'b0000001, 0, 2'd0, 4'h0, 32'h0);
    addVec(0, 0, 0, 1, 1, 2'd2, 4'hf, 32'h80000010,  1, 0, 32'h0,         7'b1001000, 1, 2'd2, 4'hf, 32'h80000010);
    addVec(1, 0, 0, 0, 0, 2'd0, 4'h0, 32'h0,         0, 0, 32'h0,         7'b0000001, 0, 2'd0, 4'h0, 32'h0);
    addVec(0, 0, 0, 0, 0, 2'd0, 4'h0, 32'h0,         0, 1, 32'h0,         7'b0000000, 0, 2'd0, 4'h0, 32'h0);
    // flush coinciding with bus_data_ok in I_DATA
    addVec(0, 0, 1, 0, 0, 2'd0, 4'h0, 32'h0,         0, 0, 32'h0,         7'b0000010, 0, 2'd0, 4'h0, 32'h0);
    addVec(0, 0, 1, 0, 0, 2'd0, 4'h0, 32'h0,         1, 0, 32'h0,         7'b1100000, 0, 2'd2, 4'h0, IA);
    addVec(0, 1, 0, 0, 0, 2'd0, 4'h0, 32'h0,         0, 1, 32'h00000005,  7'b0000010, 0, 2'd0, 4'h0, 32'h0);
    addVec(0, 0, 0, 0, 0, 2'd0, 4'h0, 32'h0,         0, 0, 32'h0,         7'b0000000, 0, 2'd0, 4'h0, 32'h0);

    // Initial reset so the first row starts from a known state
    rst = 1'b1; flush = 1'b0; inst_req = 1'b0; inst_addr = IA; data_req = 1'b0;
    data_wr = 1'b0; data_size = 2'd0; data_wstrb = 4'h0; data_addr = 32'h0;
    data_wdata = WD; bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'h0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      #2;
      checkOutput(vecs[i], i);
      @(negedge clk);
    end

    // Back-to-back simultaneous requests: first pair goes to data in both
    // builds, the second pair goes to inst only with round-robin enabled.
    rst = 1'b0; flush = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
    inst_req = 1'b1; data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2;
    data_wstrb = 4'hf; data_addr = 32'h80000040;
    #2;
    check("arb_idle_stalls", 64'({stallreq_from_ic, stallreq_from_dc}), 64'(2'b11));
    @(negedge clk);
    bus_addr_ok = 1'b1;
    #2;
    check("arb1_addr", 64'(bus_addr), 64'(32'h80000040));
    check("arb1_addr_ok", 64'({data_addr_ok, inst_addr_ok}), 64'(2'b10));
    @(negedge clk);
    bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h0; data_addr = 32'h80000044;
    #2;
    check("arb1_data_ok", 64'({data_data_ok, inst_data_ok}), 64'(2'b10));
    @(negedge clk);
    bus_data_ok = 1'b0;
    #2;
    check("arb2_idle_req", 64'(bus_req), 64'(1'b0));
    @(negedge clk);
    bus_addr_ok = 1'b1;
    #2;
    check("arb2_grant_addr", 64'({bus_wr, bus_addr}),
          INST_FIRST ? 64'({1'b0, IA}) : 64'({1'b1, 32'h80000044}));
    check("arb2_addr_ok", 64'({data_addr_ok, inst_addr_ok}),
          INST_FIRST ? 64'(2'b01) : 64'(2'b10));
    @(negedge clk);
    bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'hcafef00d;
    if (INST_FIRST) inst_req = 1'b0; else data_req = 1'b0;
    #2;
    check("arb2_data_ok", 64'({data_data_ok, inst_data_ok}),
          INST_FIRST ? 64'(2'b01) : 64'(2'b10));
    check("arb2_rdata", INST_FIRST ? 64'(inst_rdata) : 64'(data_rdata), 64'(32'hcafef00d));
    @(negedge clk);
    bus_data_ok = 1'b0;
    #2;
    check("arb3_idle_req", 64'(bus_req), 64'(1'b0));
    @(negedge clk);
    bus_addr_ok = 1'b1;
    #2;
    check("arb3_grant_addr", 64'(bus_addr), INST_FIRST ? 64'(32'h80000044) : 64'(IA));
    @(negedge clk);
    bus_addr_ok = 1'b0; bus_data_ok = 1'b1;
    if (INST_FIRST) data_req = 1'b0; else inst_req = 1'b0;
    #2;
    check("arb3_data_ok", 64'({data_data_ok, inst_data_ok}),
          INST_FIRST ? 64'(2'b10) : 64'(2'b01));
    @(negedge clk);
    bus_data_ok = 1'b0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
